// File: rtl/switch_repeat_pulser_pkg.sv
// Shared definitions for the push-button conditioner: repeat FSM states,
// default 25 MHz board timing and a range helper for the limit parameters.
package switch_repeat_pulser_pkg;

  // Default timing for the 25 MHz Go Board clock
  localparam int DEBOUNCE_10MS = 250000;
  localparam int REPEAT_500MS  = 12500000;
  localparam int REPEAT_100MS  = 2500000;
  localparam int DEFAULT_CNT_W = 24;

  // Auto-repeat controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  // True when a limit value can be held in a counter of the given width
  function automatic bit limit_fits(input int limit, input int width);
    return (limit >= 0) && ((limit >> width) == 0);
  endfunction

endpackage

// File: rtl/switch_repeat_pulser_if.sv
// Button-side bundle: the raw switch level in, and the conditioned level,
// edge pulses and auto-repeat strobes out.
interface switch_repeat_pulser_if;

  logic i_Switch;
  logic o_Level;
  logic o_Press;
  logic o_Release;
  logic o_Step;
  logic o_Held;

  // Whoever owns the button and consumes the pulses
  modport master (
    output i_Switch,
    input  o_Level,
    input  o_Press,
    input  o_Release,
    input  o_Step,
    input  o_Held
  );

  // The conditioner itself
  modport slave (
    input  i_Switch,
    output o_Level,
    output o_Press,
    output o_Release,
    output o_Step,
    output o_Held
  );

endinterface

// File: rtl/switch_repeat_pulser_sync_debounce.sv
// Two-flop synchroniser plus counting debouncer. o_Level is the stable
// debounced level; o_Rise / o_Fall pulse for one cycle in the same cycle
// o_Level changes.
module switch_repeat_pulser_sync_debounce
  import switch_repeat_pulser_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] db_count;

  // Bring the asynchronous button level into the i_Clk domain
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
    end
  end

  // Flip the stable level only after sync2 has disagreed for DEBOUNCE_LIMIT cycles
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      db_count <= '0;
      o_Level  <= 1'b0;
      o_Rise   <= 1'b0;
      o_Fall   <= 1'b0;
    end else begin
      o_Rise <= 1'b0;
      o_Fall <= 1'b0;
      if (sync2 == o_Level) begin
        db_count <= '0;
      end else if (db_count == DB_LAST) begin
        o_Level  <= sync2;
        o_Rise   <= sync2;
        o_Fall   <= ~sync2;
        db_count <= '0;
      end else begin
        db_count <= db_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_repeat_pulser.sv
// Push-button conditioner: synchronise and debounce one raw button, emit
// press/release pulses and keyboard-style auto-repeat step pulses while held.
// All outputs are registered one cycle behind the debouncer's stable level.
module switch_repeat_pulser
  import switch_repeat_pulser_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY   = REPEAT_500MS,
  parameter int REPEAT_RATE    = REPEAT_100MS,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  switch_repeat_pulser_if.slave sw
);

  // Refuse to build with limits the counters cannot represent
  if ((DEBOUNCE_LIMIT < 1) || !limit_fits(DEBOUNCE_LIMIT, CNT_W) ||
      !limit_fits(REPEAT_DELAY, CNT_W) || !limit_fits(REPEAT_RATE, CNT_W)) begin : g_bad_config
    $error("switch_repeat_pulser: timing limit out of range for CNT_W");
  end

  // A zero delay or rate turns the block into a plain press/release pulser
  localparam bit REPEAT_ON = (REPEAT_DELAY != 0) && (REPEAT_RATE != 0);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             level;
  logic             rise;
  logic             fall;
  repeat_state_t    state;
  logic [CNT_W-1:0] timer;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             step_q;
  logic             held_q;

  switch_repeat_pulser_sync_debounce #(
    .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
    .CNT_W          (CNT_W)
  ) u_sync_debounce (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Switch (sw.i_Switch),
    .o_Level  (level),
    .o_Rise   (rise),
    .o_Fall   (fall)
  );

  // Repeat FSM with shared timer; a release always wins over a timer expiry
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      timer     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      level_q   <= level;
      press_q   <= rise;
      release_q <= fall;
      step_q    <= 1'b0;
      held_q    <= (state == REPEAT);
      if (fall) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              step_q <= 1'b1;
              timer  <= '0;
              if (REPEAT_ON) begin
                state <= DELAY;
              end
            end
          end
          DELAY: begin
            if (timer == DELAY_LAST) begin
              step_q <= 1'b1;
              timer  <= '0;
              state  <= REPEAT;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          REPEAT: begin
            if (timer == RATE_LAST) begin
              step_q <= 1'b1;
              timer  <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  assign sw.o_Level   = level_q;
  assign sw.o_Press   = press_q;
  assign sw.o_Release = release_q;
  assign sw.o_Step    = step_q;
  assign sw.o_Held    = held_q;

endmodule

// File: tb/tb_switch_repeat_pulser.sv
// Self-checking bench for switch_repeat_pulser. Two instances share one raw
// button: one with auto-repeat (delay 10, rate 3) and one with repeat
// disabled (delay 0). Outputs are compared every cycle against a behavioural
// model: the debounced level flips once the last DEBOUNCE_LIMIT synchronised
// samples all disagree with it, and steps follow press-relative arithmetic.
module tb_switch_repeat_pulser;

  localparam int LIMIT = 4;
  localparam int RATE  = 3;
  localparam int W     = 8;

  logic clk;
  logic rst;
  logic raw_switch;

  int assert_count = 0;
  int fail_count   = 0;

  int    delay_cfg [2] = '{10, 0};
  string dut_name  [2] = '{"rep", "off"};

  // Behavioural model state
  int samp_q [$];
  bit stable_m;
  bit level_m;
  int press_cycle;
  int cycle_idx;

  switch_repeat_pulser_if bus_rep ();
  switch_repeat_pulser_if bus_off ();

  assign bus_rep.i_Switch = raw_switch;
  assign bus_off.i_Switch = raw_switch;

  switch_repeat_pulser #(
    .DEBOUNCE_LIMIT (LIMIT),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (RATE),
    .CNT_W          (W)
  ) dut_rep (
    .i_Clk (clk),
    .i_Rst (rst),
    .sw    (bus_rep)
  );

  switch_repeat_pulser #(
    .DEBOUNCE_LIMIT (LIMIT),
    .REPEAT_DELAY   (0),
    .REPEAT_RATE    (RATE),
    .CNT_W          (W)
  ) dut_off (
    .i_Clk (clk),
    .i_Rst (rst),
    .sw    (bus_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cycle_idx, observed, expected);
    end
  endtask

  // Synchroniser and debouncer start from all-zero history after reset
  task automatic modelReset();
    samp_q.delete();
    for (int i = 0; i < LIMIT + 2; i++) samp_q.push_back(0);
    stable_m    = 1'b0;
    level_m     = 1'b0;
    press_cycle = -1;
    cycle_idx   = 0;
  endtask

  task automatic checkAllZero(input string phase);
    logic [4:0] obs [2];
    obs[0] = {bus_rep.o_Level, bus_rep.o_Press, bus_rep.o_Release, bus_rep.o_Step, bus_rep.o_Held};
    obs[1] = {bus_off.o_Level, bus_off.o_Press, bus_off.o_Release, bus_off.o_Step, bus_off.o_Held};
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s.%s.o_Level",   phase, dut_name[k]), obs[k][4], 1'b0);
      checkOutput($sformatf("%s.%s.o_Press",   phase, dut_name[k]), obs[k][3], 1'b0);
      checkOutput($sformatf("%s.%s.o_Release", phase, dut_name[k]), obs[k][2], 1'b0);
      checkOutput($sformatf("%s.%s.o_Step",    phase, dut_name[k]), obs[k][1], 1'b0);
      checkOutput($sformatf("%s.%s.o_Held",    phase, dut_name[k]), obs[k][0], 1'b0);
    end
  endtask

  // One clock edge: advance the model with the sampled button, then compare
  task automatic stepCycle();
    bit         level_prev;
    bit         press_m;
    bit         release_m;
    bit         all_diff;
    bit         en;
    bit         step_m;
    bit         held_m;
    int         since;
    logic [4:0] obs [2];
    @(posedge clk);
    samp_q.push_back(int'(raw_switch));
    level_prev = level_m;
    level_m    = stable_m;
    all_diff   = 1'b1;
    for (int i = cycle_idx + 1; i <= cycle_idx + LIMIT; i++) begin
      if (samp_q[i] == int'(stable_m)) all_diff = 1'b0;
    end
    if (all_diff) stable_m = ~stable_m;
    press_m   = level_m & ~level_prev;
    release_m = ~level_m & level_prev;
    if (press_m) press_cycle = cycle_idx;
    #1;
    obs[0] = {bus_rep.o_Level, bus_rep.o_Press, bus_rep.o_Release, bus_rep.o_Step, bus_rep.o_Held};
    obs[1] = {bus_off.o_Level, bus_off.o_Press, bus_off.o_Release, bus_off.o_Step, bus_off.o_Held};
    for (int k = 0; k < 2; k++) begin
      en     = (delay_cfg[k] != 0) && (RATE != 0);
      since  = cycle_idx - press_cycle;
      step_m = press_m ||
               (en && (press_cycle >= 0) && level_m && (since >= delay_cfg[k]) &&
                (((since - delay_cfg[k]) % RATE) == 0));
      held_m = en && (press_cycle >= 0) && (since >= delay_cfg[k] + 1) && (level_m || release_m);
      checkOutput($sformatf("%s.o_Level",   dut_name[k]), obs[k][4], level_m);
      checkOutput($sformatf("%s.o_Press",   dut_name[k]), obs[k][3], press_m);
      checkOutput($sformatf("%s.o_Release", dut_name[k]), obs[k][2], release_m);
      checkOutput($sformatf("%s.o_Step",    dut_name[k]), obs[k][1], step_m);
      checkOutput($sformatf("%s.o_Held",    dut_name[k]), obs[k][0], held_m);
    end
    cycle_idx++;
  endtask

  // Hold the raw button at one level for a number of checked cycles
  task automatic applyStimulus(input logic value, input int cycles);
    raw_switch = value;
    repeat (cycles) stepCycle();
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear at once and stay clear
  task automatic applyReset(input int cycles);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      checkAllZero("midrst");
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    rst        = 1'b1;
    raw_switch = 1'b1;
    modelReset();
    #1;
    checkAllZero("rst");
    repeat (3) begin
      @(posedge clk);
      #1;
      checkAllZero("rst");
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    $display("[TB] held through reset: press expected 6 cycles after release");
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 12);

    $display("[TB] glitch rejection");
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 12);

    $display("[TB] single short press");
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 14);

    $display("[TB] long hold with auto-repeat");
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 14);

    $display("[TB] release colliding with repeat expiry");
    applyStimulus(1'b1, 13);
    applyStimulus(1'b0, 14);

    $display("[TB] reset while repeating");
    applyStimulus(1'b1, 25);
    applyReset(2);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 12);

    $display("[TB] randomized segments");
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 7) == 0) begin
        applyReset(int'($urandom_range(1, 3)));
      end
      applyStimulus(logic'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
    end
    applyStimulus(1'b0, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/switch_repeat_pulser.md
Name: switch_repeat_pulser

Overview:
Upstream input conditioner for the seven-segment counter projects. It performs the following steps on one raw Go Board push-button:
- synchronises the button to i_Clk;
- debounces it;
- emits single-cycle press and release pulses;
- generates keyboard-style auto-repeat step pulses while the button is held.

The digit counter consumes o_Step directly, so it needs no edge detector of its own.

Parameters:
DEBOUNCE_LIMIT, 250000, cycles the synchronised input must differ from the stable level before the stable level flips (10 ms at 25 MHz); must be >= 1.
REPEAT_DELAY, 12500000, cycles from o_Press to the first auto-repeat step (500 ms); 0 disables auto-repeat.
REPEAT_RATE, 2500000, cycles between subsequent auto-repeat steps (100 ms); 0 disables auto-repeat.
CNT_W, 24, width of the debounce and repeat counters; every limit parameter must be < 2**CNT_W (elaboration-time check).

Ports:
i_Clk  input  1  system clock, 25 MHz
i_Rst  input  1  reset, asynchronous, active-high
i_Switch  input  1  raw, asynchronous button level; 1 = pressed
o_Level  output  1  debounced stable level
o_Press  output  1  one-cycle pulse on debounced 0->1
o_Release  output  1  one-cycle pulse on debounced 1->0
o_Step  output  1  one-cycle pulse on each press and on each auto-repeat
o_Held  output  1  high while in the REPEAT state (auto-repeat active)

Behaviour:
- Clocking and reset: one clock, i_Clk; reset is asynchronous and active-high on i_Rst.
- While i_Rst = 1, the following are all 0:
  - sync flops, stable level, both counters;
  - state = IDLE;
  - all outputs: o_Level, o_Press, o_Release, o_Step, o_Held.
- Synchroniser: two flops; sync2 is the synchronised input.
- Debounce:
  - If sync2 == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_LIMIT-1 and sync2 still differs, stable <= sync2 and the counter clears.
  - A glitch shorter than DEBOUNCE_LIMIT cycles never reaches stable.
- Latency: a clean raw edge appears on o_Level DEBOUNCE_LIMIT+2 cycles after the first clock edge that samples it.
- o_Level = stable (registered).
- o_Press / o_Release are asserted in the same cycle o_Level changes. They are registered together with stable and last exactly 1 cycle.
- FSM states IDLE, DELAY, REPEAT; one shared repeat timer (CNT_W bits).
  - IDLE: on the stable rise, pulse o_Step with o_Press, clear the timer, go to DELAY.
  - DELAY: the timer increments.
    - At timer == REPEAT_DELAY-1: pulse o_Step, clear the timer, go to REPEAT.
  - REPEAT: o_Held = 1; the timer increments.
    - At timer == REPEAT_RATE-1: pulse o_Step, clear the timer.
  - Any state: on the stable fall, go to IDLE, clear the timer, o_Held = 0 the next cycle.
  - If REPEAT_DELAY == 0 or REPEAT_RATE == 0: DELAY and REPEAT are never entered. o_Step then equals o_Press only.
- Simultaneous release and timer expiry in the same cycle: the release wins. No o_Step is issued, o_Release pulses, next state is IDLE.
- o_Step never pulses on a release and never pulses two cycles in a row (REPEAT_RATE >= 2 recommended; REPEAT_RATE = 1 gives a continuous step stream and is allowed).
- Reset mid-operation:
  - All state clears immediately, with no pulse emitted during reset.
  - If the button is still held after reset deasserts, it is treated as a new press: o_Press and o_Step occur after the full debounce latency.
- Timer and debounce counters saturate logically via the compare; they never wrap in legal configurations.

Decomposition:
- Shared Verilog include (switch_pkg.vh) holds:
  - FSM state localparams: IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2;
  - default timing constants for the 25 MHz board: DEBOUNCE_10MS, REPEAT_500MS, REPEAT_100MS.
- One natural sub-module, switch_sync_debounce: the two-flop synchroniser, debounce counter, stable level and edge pulses (i_Clk, i_Rst, i_Switch -> o_Level, o_Rise, o_Fall).
- The top level adds the repeat FSM and timer.

Test Plan:
All scenarios use DEBOUNCE_LIMIT = 4, REPEAT_DELAY = 10, REPEAT_RATE = 3, CNT_W = 8.
- Reset: hold i_Rst 3 cycles with i_Switch = 1 -> all outputs 0 during reset. After release, o_Level = 1 and o_Press = o_Step = 1 on cycle 6 after the deassertion edge.
- Glitch rejection: i_Switch high for 3 cycles then low -> o_Level, o_Press and o_Step stay 0 throughout.
- Single press: i_Switch 0->1 at edge 0, held 8 cycles, then 0:
  - o_Level rises at edge 6 with o_Press = o_Step = 1 for exactly 1 cycle;
  - o_Release pulses 6 cycles after the fall;
  - no repeat step occurs.
- Auto-repeat: hold for 40 cycles -> o_Step at press cycle P, then P+10, P+13, P+16, ... o_Held = 1 from P+11 until the cycle after the stable fall.
- Release/expiry collision: arrange the stable fall exactly at P+13 -> o_Release = 1, o_Step = 0 that cycle, FSM returns to IDLE.
- Disabled repeat: REPEAT_DELAY = 0, hold 40 cycles -> exactly one o_Step (with o_Press), o_Held never asserts.
